sequencer: RTL and testbench
============================

# sequencer

Machine-cycle / clock-period sequencer for the CPU control unit. Generates the one-hot M-cycle (M1..M6) and T-state (T1..T6) timing that every control block keys off, including the M1 and T2 strobes consumed by the reset block. It sits between instruction decode and the reset and timing-matrix logic.
- Decode requests M-cycle ends and jumps back to M1.
- Pin-level WAIT and BUSRQ, already synchronised upstream, stretch or freeze the sequence.

## Interface
Parameters:
- NUM_M, 6, number of M-cycles (one-hot width of `m`)
- NUM_T, 6, number of T-states (one-hot width of `t`)

Ports:
- clk  input  1  CPU clock; all state changes on rising edge
- nreset  input  1  synchronous, active-low reset, sampled on clk rising edge
- nextM  input  1  decode: current T-state is the last of this M-cycle
- setM1  input  1  decode: next M-cycle is M1 (qualifies nextM)
- hold  input  1  synchronised WAIT; only honoured in T2
- busrq  input  1  synchronised bus request, active high
- m  output  NUM_M  one-hot M-cycle, bit 0 = M1
- t  output  NUM_T  one-hot T-state, bit 0 = T1
- M1  output  1  equals m[0]
- T2  output  1  equals t[1]
- busack  output  1  bus granted; sequence frozen
- fetch  output  1  single-cycle strobe, high while M1 and T1

## Operation
- Two-state FSM: RUN and GRANT. Reset goes to RUN.
- Reset values (nreset low at an edge): m=000001, t=000001, busack=0, FSM=RUN.
  - Reset wins over every other input.
  - Reset mid-cycle, including during GRANT, goes straight to M1/T1.
- RUN, each edge, evaluated in priority order:
  1. **Wait.** If t==T2 and hold=1: m and t unchanged (wait state). Any number of wait cycles is allowed. nextM is ignored while waiting.
  2. **End of M-cycle.** If nextM=1, or t==T_NUM_T:
     - t → T1.
     - m → M1 if setM1=1 or m==M_NUM_M. Otherwise m shifts left one place.
     - If busrq=1 at this same edge: FSM → GRANT and busack → 1 on this edge. m/t take the advanced values above and hold them.
  3. **Otherwise.** t shifts left one place and m is unchanged.
- Reaching T_NUM_T without nextM forces an end of M-cycle (saturation guard). M_NUM_M wraps to M1.
- GRANT:
  - m, t and busack=1 are held.
  - When busrq=0 at an edge: FSM → RUN and busack → 0. The held m/t then advance normally from the following edge.
- busrq is sampled only at M-cycle boundaries. A busrq pulse in mid-cycle that drops before the boundary is ignored.
- hold outside T2 has no effect.
- M1, T2 and fetch are pure decodes of registered state (no combinational path from inputs).
- m and t are always exactly one-hot.

## Timing
- All outputs are registered; one-cycle latency from a sampled input to its effect.
- Minimum M-cycle: 2 T-states (nextM asserted in T2, hold=0).
  - Opcode fetch (M1) is normally 4: nextM in T4.
- A wait inserted in T2 adds exactly one clock per cycle that hold=1.
- Bus grant:
  - busack rises on the boundary edge.
  - busack falls one edge after busrq is seen low.
  - The first T1 after grant is visible in the same cycle busack drops (state was already advanced).
- fetch is high for exactly one clock per M1 (longer only if reset is held).

## Structure
- Shared control package holds:
  - index constants M1_IDX..M6_IDX and T1_IDX..T6_IDX
  - the FSM enum {RUN, GRANT}
  - NUM_M and NUM_T defaults
- Single module. The one-hot shift with wrap and load-to-first is written twice (m and t), so a small sub-module `onehot_ring` (shift, load-first, hold) is natural; instantiate it twice.

## Test plan
- **Reset and free run.** Hold nreset=0 for 3 clocks, then release. nextM asserted in T4 each cycle, setM1=1 → m=000001 throughout; t cycles 1,2,4,8 then back to 1; fetch high once per 4 clocks.
- **Multi-M sequence.** nextM in T3 of M1, T3 of M2, T3 of M3 with setM1=1 → m goes 1→2→4→1; every M-cycle is 3 T-states.
- **Wait states.** hold=1 for 3 clocks entering T2 of M1 → t stays 000010 for 4 clocks total; T3 follows once hold=0. hold=1 in T3 → no effect.
- **Bus request.** busrq=1 from mid-M1 until 5 clocks after the boundary → at the boundary busack=1, m=000010, t=000001, frozen. busack=0 one edge after busrq falls; t=T2 on the next edge.
- **Saturation and reset mid-operation.** Never assert nextM → t reaches T6, then m advances and t=T1. Repeat through M6 → m wraps to M1. Assert nreset=0 during GRANT → m=M1, t=T1 and busack=0 after that edge.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared control definitions for the M-cycle / T-state sequencer:
// one-hot bit positions, FSM encoding and default ring widths.
package sequencer_pkg;

  localparam int unsigned NUM_M_DEF = 6;
  localparam int unsigned NUM_T_DEF = 6;

  localparam int unsigned M1_IDX = 0;
  localparam int unsigned M2_IDX = 1;
  localparam int unsigned M3_IDX = 2;
  localparam int unsigned M4_IDX = 3;
  localparam int unsigned M5_IDX = 4;
  localparam int unsigned M6_IDX = 5;

  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

  typedef enum logic {
    RUN   = 1'b0,
    GRANT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/sequencer_onehot_ring.sv
// One-hot ring register: reset and load_first go to bit 0, shift rotates
// left with wrap, otherwise the value is held.
module onehot_ring #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             shift,
  input  logic             load_first,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      q <= WIDTH'(1);
    end else if (load_first) begin
      q <= WIDTH'(1);
    end else if (shift) begin
      q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

endmodule

// File: rtl/sequencer.sv
// Machine-cycle / T-state sequencer: one-hot M and T timing with WAIT
// stretching in T2 and bus-request freeze at M-cycle boundaries.
module sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned NUM_M = NUM_M_DEF,
  parameter int unsigned NUM_T = NUM_T_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nextM,
  input  logic             setM1,
  input  logic             hold,
  input  logic             busrq,
  output logic [NUM_M-1:0] m,
  output logic [NUM_T-1:0] t,
  output logic             M1,
  output logic             T2,
  output logic             busack,
  output logic             fetch
);

  seq_state_e state, state_next;

  logic waiting;
  logic end_m;
  logic m_last;
  logic t_last;
  logic m_shift, m_load;
  logic t_shift, t_load;

  assign m_last  = m[NUM_M-1];
  assign t_last  = t[NUM_T-1];
  assign waiting = t[T2_IDX] & hold;
  // The last T-state forces a boundary even if decode never asks for one.
  assign end_m   = ~waiting & (nextM | t_last);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (end_m && busrq) state_next = GRANT;
      GRANT:   if (!busrq)         state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    m_shift = 1'b0;
    m_load  = 1'b0;
    t_shift = 1'b0;
    t_load  = 1'b0;
    busack  = (state == GRANT);
    // The boundary advance happens on the same edge that enters GRANT, so
    // the frozen values are already the post-boundary ones.
    if (state == RUN) begin
      t_load  = end_m;
      t_shift = ~waiting & ~end_m;
      m_load  = end_m & (setM1 | m_last);
      m_shift = end_m & ~(setM1 | m_last);
    end
  end

  onehot_ring #(.WIDTH(NUM_M)) u_m_ring (
    .clk        (clk),
    .nreset     (nreset),
    .shift      (m_shift),
    .load_first (m_load),
    .q          (m)
  );

  onehot_ring #(.WIDTH(NUM_T)) u_t_ring (
    .clk        (clk),
    .nreset     (nreset),
    .shift      (t_shift),
    .load_first (t_load),
    .q          (t)
  );

  assign M1    = m[M1_IDX];
  assign T2    = t[T2_IDX];
  assign fetch = m[M1_IDX] & t[T1_IDX];

endmodule

// File: tb/tb_sequencer.sv
// Directed self-checking bench for the sequencer.
module tb_sequencer;

  logic       clk;
  logic       nreset;
  logic       nextM;
  logic       setM1;
  logic       hold;
  logic       busrq;
  logic [5:0] m;
  logic [5:0] t;
  logic       M1;
  logic       T2;
  logic       busack;
  logic       fetch;

  int unsigned n_checks;
  int unsigned n_fail;

  sequencer #(.NUM_M(6), .NUM_T(6)) dut (
    .clk    (clk),
    .nreset (nreset),
    .nextM  (nextM),
    .setM1  (setM1),
    .hold   (hold),
    .busrq  (busrq),
    .m      (m),
    .t      (t),
    .M1     (M1),
    .T2     (T2),
    .busack (busack),
    .fetch  (fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [5:0] em, input logic [5:0] et,
                             input logic eack);
    check_eq({tag, ".m"}, 32'(m), 32'(em));
    check_eq({tag, ".t"}, 32'(t), 32'(et));
    check_eq({tag, ".busack"}, 32'(busack), 32'(eack));
    check_eq({tag, ".M1"}, 32'(M1), 32'(em[0]));
    check_eq({tag, ".T2"}, 32'(T2), 32'(et[1]));
    check_eq({tag, ".fetch"}, 32'(fetch), 32'(em[0] & et[0]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset = 1'b0;
    nextM  = 1'b1;
    setM1  = 1'b0;
    hold   = 1'b1;
    busrq  = 1'b1;

    // Reset wins over asserted inputs
    repeat (3) tick();
    check_state("reset", 6'h01, 6'h01, 1'b0);
    nextM = 1'b0; hold = 1'b0; busrq = 1'b0;
    nreset = 1'b1;

    // Free run, opcode fetch of 4 T-states with setM1
    setM1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_state("run.t1", 6'h01, 6'h01, 1'b0);
      tick(); check_state("run.t2", 6'h01, 6'h02, 1'b0);
      tick(); check_state("run.t3", 6'h01, 6'h04, 1'b0);
      tick(); check_state("run.t4", 6'h01, 6'h08, 1'b0);
      nextM = 1'b1;
      tick();
      nextM = 1'b0;
    end
    check_state("run.end", 6'h01, 6'h01, 1'b0);

    // Multi-M sequence, 3 T-states each
    setM1 = 1'b0;
    tick(); tick(); check_state("mm.m1t3", 6'h01, 6'h04, 1'b0);
    nextM = 1'b1; tick(); nextM = 1'b0;
    check_state("mm.m2t1", 6'h02, 6'h01, 1'b0);
    tick(); tick(); check_state("mm.m2t3", 6'h02, 6'h04, 1'b0);
    nextM = 1'b1; tick(); nextM = 1'b0;
    check_state("mm.m3t1", 6'h04, 6'h01, 1'b0);
    tick(); tick(); check_state("mm.m3t3", 6'h04, 6'h04, 1'b0);
    nextM = 1'b1; setM1 = 1'b1; tick(); nextM = 1'b0;
    check_state("mm.back", 6'h01, 6'h01, 1'b0);

    // Wait states: hold in T1 ignored, 3 waits in T2, nextM ignored while waiting
    hold = 1'b1;
    tick(); check_state("wait.enter", 6'h01, 6'h02, 1'b0);
    tick(); check_state("wait.1", 6'h01, 6'h02, 1'b0);
    tick(); check_state("wait.2", 6'h01, 6'h02, 1'b0);
    nextM = 1'b1;
    tick(); check_state("wait.3", 6'h01, 6'h02, 1'b0);
    nextM = 1'b0; hold = 1'b0;
    tick(); check_state("wait.t3", 6'h01, 6'h04, 1'b0);
    hold = 1'b1;
    tick(); check_state("wait.holdt3", 6'h01, 6'h08, 1'b0);
    hold = 1'b0; nextM = 1'b1;
    tick(); nextM = 1'b0;
    check_state("wait.end", 6'h01, 6'h01, 1'b0);

    // Bus request from mid-M1, grant at boundary
    setM1 = 1'b0;
    tick(); check_state("bus.t2", 6'h01, 6'h02, 1'b0);
    busrq = 1'b1;
    tick(); check_state("bus.mid", 6'h01, 6'h04, 1'b0);
    tick(); check_state("bus.t4", 6'h01, 6'h08, 1'b0);
    nextM = 1'b1;
    tick(); nextM = 1'b0;
    check_state("bus.grant", 6'h02, 6'h01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); check_state("bus.frozen", 6'h02, 6'h01, 1'b1);
    end
    busrq = 1'b0;
    tick(); check_state("bus.release", 6'h02, 6'h01, 1'b0);
    tick(); check_state("bus.resume", 6'h02, 6'h02, 1'b0);
    // Mid-cycle pulse that drops before the boundary is ignored
    busrq = 1'b1;
    tick(); check_state("bus.pulse", 6'h02, 6'h04, 1'b0);
    busrq = 1'b0; nextM = 1'b1; setM1 = 1'b1;
    tick(); nextM = 1'b0; setM1 = 1'b0;
    check_state("bus.nopulse", 6'h01, 6'h01, 1'b0);

    // Saturation through all M-cycles with wrap back to M1
    for (int mi = 0; mi < 6; mi++) begin
      for (int ti = 0; ti < 6; ti++) begin
        check_state("sat", 6'(1 << mi), 6'(1 << ti), 1'b0);
        tick();
      end
    end
    check_state("sat.wrap", 6'h01, 6'h01, 1'b0);

    // Reset during GRANT
    tick();
    busrq = 1'b1; nextM = 1'b1;
    tick(); nextM = 1'b0;
    check_state("rg.grant", 6'h02, 6'h01, 1'b1);
    nreset = 1'b0;
    tick(); check_state("rg.reset", 6'h01, 6'h01, 1'b0);
    nreset = 1'b1; busrq = 1'b0;
    tick(); check_state("rg.after", 6'h01, 6'h02, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
